// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the single-cycle RV32 core.
//
// This block owns the program counter. It drives a synchronous instruction
// memory and presents one instruction per cycle, together with a valid flag,
// to the decoder. The decoder's branch_taken / imm12 / halt outputs for the
// current valid instruction either redirect the stream or freeze it.
//
// Parameters:
//   RESET_PC  PC loaded on reset (bits [1:0] must be zero)
//   IMEM_AW   instruction memory word-address width
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   imem_addr     word address presented to memory (fetch_pc[IMEM_AW+1:2])
//   imem_rdata    memory word for the address presented in the previous cycle
//   stall         consumer cannot accept; hold the current instruction
//   branch_taken  redirect request for the current valid instruction
//   imm12         B-type offset (bit 0 zero), sign-extended to 32 bits
//   halt          halt request for the current valid instruction
//   instr         current instruction (0 while instr_valid is low)
//   instr_valid   instr/pc hold a live instruction
//   pc            address of instr
//   halted        fetch stopped until reset
//   misalign      misaligned redirect target trapped (optional port)
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect target with bit 1 set
//                           halts fetch and raises the sticky misalign port;
//                           otherwise target bits [1:0] are cleared and the
//                           redirect proceeds.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [11:0]        imm12,
  input  logic               halt,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic               halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               misalign
`endif
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] hold_word;
  logic        hold_valid;
  logic [31:0] target;

  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign target    = pc + {{20{imm12[11]}}, imm12};

  // Memory data lags the address by one cycle, so on the first stalled cycle
  // imem_rdata is still the live instruction; after that the memory already
  // returns the word at fetch_pc, hence the hold register takes over.
  always_comb begin
    instr = '0;
    if (instr_valid) begin
      instr = hold_valid ? hold_word : imem_rdata;
    end
  end

  // In RUN, instr_valid low marks the squashed slot that follows a redirect;
  // that slot advances exactly like the FILL cycle, with fetch_pc holding the
  // redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      fetch_pc    <= RESET_PC;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      hold_word   <= '0;
      hold_valid  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (!stall) begin
            pc          <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
            instr_valid <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          if (stall) begin
            if (!hold_valid) begin
              hold_word  <= imem_rdata;
              hold_valid <= 1'b1;
            end
          end else begin
            hold_valid <= 1'b0;
            if (!instr_valid) begin
              pc          <= fetch_pc;
              fetch_pc    <= fetch_pc + 32'd4;
              instr_valid <= 1'b1;
            end else if (halt) begin
              state       <= HALTED;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end else if (branch_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              if (target[1]) begin
                state       <= HALTED;
                instr_valid <= 1'b0;
                halted      <= 1'b1;
                misalign    <= 1'b1;
              end else begin
                pc          <= fetch_pc;
                fetch_pc    <= target & ~32'h3;
                instr_valid <= 1'b0;
              end
`else
              pc          <= fetch_pc;
              fetch_pc    <= target & ~32'h3;
              instr_valid <= 1'b0;
`endif
            end else begin
              pc       <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
            end
          end
        end

        HALTED: begin
          // absorbing; only rst leaves
        end

        default: begin
          state       <= FILL;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned AW       = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          stall;
  logic          branch_taken;
  logic [11:0]   imm12;
  logic          halt;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [31:0]   pc;
  logic          halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic          misalign;
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];

  // reference model of the architectural instruction stream
  bit          m_valid;
  bit          m_halted;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_next;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .IMEM_AW  (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .imm12        (imm12),
    .halt         (halt),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .halted       (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign     (misalign)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    return mem[w];
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [31:0] a);
    logic [31:0] n;
    n = a + 32'd4;
    return n[9:2];
  endfunction

  // Applies inputs for one cycle, advances the model across the edge and
  // returns at the following falling edge for sampling.
  task automatic tick(input bit r, input bit s, input bit b, input bit h,
                      input logic [11:0] imm);
    int          off;
    logic [31:0] tgt;
    rst = r; stall = s; branch_taken = b; halt = h; imm12 = imm;
    @(posedge clk);
    off = $signed(imm);
    tgt = m_pc + off;
    if (r) begin
      m_valid = 0; m_halted = 0; m_mis = 0; m_pc = RESET_PC; m_next = RESET_PC;
    end else if (m_halted || s) begin
      // nothing moves
    end else if (!m_valid) begin
      m_valid = 1; m_pc = m_next; m_next = m_pc + 4;
    end else if (h) begin
      m_halted = 1; m_valid = 0;
    end else if (b) begin
      if (MIS_EN && tgt[1]) begin
        m_halted = 1; m_mis = 1; m_valid = 0;
      end else begin
        m_valid = 0; m_next = tgt & ~32'h3;
      end
    end else begin
      m_pc = m_pc + 4; m_next = m_pc + 4;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 12'h0);
    tick(1, 0, 0, 0, 12'h0);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid);
    end
    checks++;
    if (halted !== 1'b0) begin
      failures++; $display("FAIL reset_halted got=%b exp=0", halted);
    end
    checks++;
    if (pc !== RESET_PC) begin
      failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC);
    end
    checks++;
    if (instr !== 32'h0) begin
      failures++; $display("FAIL reset_instr got=%h exp=0", instr);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (misalign !== 1'b0) begin
      failures++; $display("FAIL reset_misalign got=%b exp=0", misalign);
    end
`endif
  endtask

  task automatic test_startup;
    tick(1, 0, 0, 0, 12'h0);
    tick(0, 0, 0, 0, 12'h0);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00500093 || pc !== 32'h0) begin
      failures++;
      $display("FAIL startup_first got=%b/%h/%h exp=1/00500093/00000000",
               instr_valid, instr, pc);
    end
    for (int i = 1; i < 6; i++) begin
      tick(0, 0, 0, 0, 12'h0);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'(4 * i) || instr !== mem[i]) begin
        failures++;
        $display("FAIL startup_seq got=%b/%h/%h exp=1/%h/%h",
                 instr_valid, pc, instr, 32'(4 * i), mem[i]);
      end
    end
  endtask

  task automatic test_branch;
    tick(1, 0, 0, 0, 12'h0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 12'h0);   // pc = 0x8
    tick(0, 0, 1, 0, 12'hFF8);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL branch_bubble got=%b exp=0", instr_valid);
    end
    tick(0, 0, 0, 0, 12'h0);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== mem[0]) begin
      failures++;
      $display("FAIL branch_target got=%b/%h/%h exp=1/00000000/%h",
               instr_valid, pc, instr, mem[0]);
    end
  endtask

  task automatic test_stall;
    tick(1, 0, 0, 0, 12'h0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 12'h0);   // pc = 0x10
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 12'h0);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h10 || instr !== mem[4]) begin
        failures++;
        $display("FAIL stall_hold got=%b/%h/%h exp=1/00000010/%h",
                 instr_valid, pc, instr, mem[4]);
      end
    end
    tick(0, 0, 0, 0, 12'h0);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h14 || instr !== mem[5]) begin
      failures++;
      $display("FAIL stall_release got=%b/%h/%h exp=1/00000014/%h",
               instr_valid, pc, instr, mem[5]);
    end
  endtask

  task automatic test_halt;
    tick(1, 0, 0, 0, 12'h0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 12'h0);   // pc = 0xC
    tick(0, 0, 1, 1, 12'h010);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'hC) begin
        failures++;
        $display("FAIL halt_frozen got=%b/%b/%h exp=1/0/0000000c",
                 halted, instr_valid, pc);
      end
      tick(0, i[0], 1, i[1], 12'h008);
    end
    tick(1, 0, 0, 0, 12'h0);
    checks++;
    if (halted !== 1'b0 || instr_valid !== 1'b0 || pc !== RESET_PC) begin
      failures++;
      $display("FAIL halt_reset got=%b/%b/%h exp=0/0/%h",
               halted, instr_valid, pc, RESET_PC);
    end
    tick(0, 0, 0, 0, 12'h0);
    checks++;
    if (instr_valid !== 1'b1 || pc !== RESET_PC || instr !== mem[0]) begin
      failures++;
      $display("FAIL halt_restart got=%b/%h/%h exp=1/%h/%h",
               instr_valid, pc, instr, RESET_PC, mem[0]);
    end
  endtask

  task automatic test_wrap;
    tick(1, 0, 0, 0, 12'h0);
    for (int i = 0; i < 255; i++) tick(0, 0, 0, 0, 12'h0); // pc = 0x3F8
    checks++;
    if (pc !== 32'h3F8 || imem_addr !== 8'd255) begin
      failures++; $display("FAIL wrap_pre got=%h/%0d exp=000003f8/255", pc, imem_addr);
    end
    tick(0, 0, 0, 0, 12'h0);
    checks++;
    if (pc !== 32'h3FC || imem_addr !== 8'd0 || instr !== mem[255]) begin
      failures++;
      $display("FAIL wrap_edge got=%h/%0d/%h exp=000003fc/0/%h", pc, imem_addr, instr, mem[255]);
    end
    tick(0, 0, 0, 0, 12'h0);
    checks++;
    if (pc !== 32'h400 || imem_addr !== 8'd1 || instr !== mem[0]) begin
      failures++;
      $display("FAIL wrap_post got=%h/%0d/%h exp=00000400/1/%h", pc, imem_addr, instr, mem[0]);
    end
  endtask

  task automatic test_misalign;
    tick(1, 0, 0, 0, 12'h0);
    tick(0, 0, 0, 0, 12'h0);                                // pc = 0x0
    tick(0, 0, 1, 0, 12'h006);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (misalign !== 1'b1 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL misalign_trap got=%b/%b/%b exp=1/1/0", misalign, halted, instr_valid);
      end
      tick(0, 0, 1, 0, 12'h004);
    end
`else
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL misalign_bubble got=%b exp=0", instr_valid);
    end
    tick(0, 0, 0, 0, 12'h0);
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== mem[1] || halted !== 1'b0) begin
      failures++;
      $display("FAIL misalign_redirect got=%b/%h/%h/%b exp=1/00000004/%h/0",
               instr_valid, pc, instr, halted, mem[1]);
    end
`endif
  endtask

  task automatic test_random;
    logic [11:0] imm;
    bit          r, s, b, h;
    tick(1, 0, 0, 0, 12'h0);
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 20);
      b   = ($urandom_range(0, 99) < 15);
      h   = ($urandom_range(0, 99) < 3);
      imm = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) != 0) imm = imm & 12'hFFC;
      else imm = imm & 12'hFFE;
      tick(r, s, b, h, imm);
      checks++;
      if (instr_valid !== m_valid || halted !== m_halted) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got=%b/%b exp=%b/%b",
                 i, instr_valid, halted, m_valid, m_halted);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++;
      if (misalign !== m_mis) begin
        failures++; $display("FAIL rand_misalign cyc=%0d got=%b exp=%b", i, misalign, m_mis);
      end
`endif
      if (m_valid) begin
        checks++;
        if (pc !== m_pc || instr !== exp_word(m_pc) || imem_addr !== exp_addr(m_pc)) begin
          failures++;
          $display("FAIL rand_stream cyc=%0d got=%h/%h/%0d exp=%h/%h/%0d",
                   i, pc, instr, imem_addr, m_pc, exp_word(m_pc), exp_addr(m_pc));
        end
      end
      if (m_halted) begin
        checks++;
        if (pc !== m_pc) begin
          failures++; $display("FAIL rand_halt_pc cyc=%0d got=%h exp=%h", i, pc, m_pc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom ^ 32'(i);
    mem[0] = 32'h00500093;
    mem[5] = ~mem[4];
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0; imm12 = '0;
    m_valid = 0; m_halted = 0; m_mis = 0; m_pc = RESET_PC; m_next = RESET_PC;
    @(negedge clk);
    test_reset;
    test_startup;
    test_branch;
    test_stall;
    test_halt;
    test_wrap;
    test_misalign;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
